// File: rtl/progloader.sv
// Program-memory loader: byte stream -> 16-bit words (high byte first) written from address 0, XOR-checked.
// Latency: each word is written the cycle after its low byte is accepted; done/error rise the cycle after the last byte.
// Backpressure: in_ready is registered and held for the whole receive phase; the source may stall freely.
//
// Ports: clk/reset (sync, active-low); start pulse; in_data/in_valid/in_ready byte stream;
//        mem_we/mem_wa/mem_wd program memory write port; cpu_hold, busy, sticky done/error status.
module progloader #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_wa,
    output logic [DW-1:0] mem_wd,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(2 ** AW);

    state_t      state;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [7:0]  chk;
    logic [15:0] len;
    // One bit wider than the address so a full 2^AW image terminates without wrapping to 0.
    logic [AW:0] cnt;

    logic        acc;
    logic [16:0] len_new;
    logic [15:0] cnt_inc;

    assign acc     = in_valid && in_ready;
    assign len_new = {1'b0, len_hi, in_data};
    assign cnt_inc = 16'(cnt) + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_wa   <= '0;
            mem_wd   <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            len_hi   <= '0;
            data_hi  <= '0;
            chk      <= '0;
            len      <= '0;
            cnt      <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cnt      <= '0;
                        chk      <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (acc) begin
                        len_hi <= in_data;
                        chk    <= chk ^ in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (acc) begin
                        chk <= chk ^ in_data;
                        len <= len_new[15:0];
                        if (len_new == 17'd0 || len_new > MAX_WORDS) begin
                            // Bad length: abort before any write; CPU stays held.
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (acc) begin
                        data_hi <= in_data;
                        chk     <= chk ^ in_data;
                        state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (acc) begin
                        chk    <= chk ^ in_data;
                        mem_we <= 1'b1;
                        mem_wa <= cnt[AW-1:0];
                        mem_wd <= {data_hi, in_data};
                        cnt    <= cnt + 1'b1;
                        state  <= (cnt_inc == len) ? S_CHK : S_DATA_HI;
                    end
                end
                S_CHK: begin
                    if (acc) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == chk) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            // Partial or corrupt image: keep the CPU held.
                            error <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                end
                // One-cycle terminal states; a start seen here is deliberately dropped.
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/progloader.md
# progloader

Program-memory loader for the single-cycle CPU. Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first), and writes them sequentially from address 0 into the write port of the 1024×16 program memory, which the CPU reads asynchronously. It holds the CPU in reset while loading. An XOR checksum validates the image.

## Interface
- AW, 10, program memory address width (depth 2^AW = 1024 words)
- DW, 16, instruction word width (fixed at 2 bytes)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse; begins a load when idle
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  program memory write enable (one-cycle pulse)
- mem_wa  out  AW  program memory write address
- mem_wd  out  DW  program memory write data
- cpu_hold  out  1  keeps CPU in reset / PC at 0
- busy  out  1  load in progress
- done  out  1  sticky: last load succeeded
- error  out  1  sticky: last load failed

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then N words as HI, LO bytes, then one CHK byte.
- A byte is accepted when in_valid && in_ready on a rising edge. in_data must not be sampled otherwise.
- FSM states:
  - IDLE: in_ready=0. start → LEN_HI; clears done/error, sets busy and cpu_hold, clears word counter and chk.
  - LEN_HI → LEN_LO → check: N==0 or N>2^AW → ERR, else DATA_HI.
  - DATA_HI: latch high byte → DATA_LO.
  - DATA_LO: latch low byte; schedule a write of word {hi,lo} at address = word counter; increment counter. If counter reaches N → CHK, else → DATA_HI.
  - CHK: compare the byte with the running chk. Equal → DONE, else → ERR.
  - DONE: done=1, busy=0, cpu_hold=0 → IDLE.
  - ERR: error=1, busy=0, cpu_hold stays 1 (partial image never executed) → IDLE.
- chk = XOR of every accepted byte, LEN_HI/LEN_LO included, CHK excluded.
- Word counter is AW+1 bits so that N=1024 terminates without address wrap. mem_wa = counter[AW-1:0].
- start while busy is ignored. start in the same cycle as DONE/ERR is ignored; the next start is honoured from IDLE.
- cpu_hold stays 1 after ERR until a later load succeeds.

## Timing
- Reset (reset=0 at clock edge): state IDLE, in_ready=0, mem_we=0, mem_wa=0, mem_wd=0, cpu_hold=0, busy=0, done=0, error=0, counters/chk=0. Reset mid-load aborts immediately. Writes already performed remain in memory; no further writes occur.
- in_ready is registered and equals 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK. The source may stall arbitrarily; the loader never drops ready mid-state except on a state transition out of the receiving states.
- Throughput is one byte per cycle. Back-to-back bytes need no idle cycles.
- Write latency: mem_we, mem_wa, and mem_wd are registered and valid the cycle after the LO byte is accepted, for exactly one cycle. mem_wa/mem_wd hold their values otherwise.
- busy rises the cycle after start is sampled. done/error rise the cycle after CHK (or the offending length) is accepted. cpu_hold falls in the same cycle that done rises.
- Last write (word N-1) completes before done rises.

## Test plan
- Load N=3: words 0x1234, 0xABCD, 0x0001, correct CHK = 0x00^0x03^0x12^0x34^0xAB^0xCD^0x00^0x01 → mem[0..2] written with those values, mem_we pulses 3 times, done=1, cpu_hold=0.
- Same stream with CHK flipped by 0x01 → all 3 writes occur, error=1, done=0, cpu_hold=1.
- Length 0x0000 and length 0x0401 → error=1 right after LEN_LO, no mem_we, in_ready=0.
- N=1024 with random in_valid gaps → 1024 writes at addresses 0..1023, no write to 0 after 1023, done=1.
- Assert reset=0 after the 5th data word → all outputs at reset values next cycle. A new start loads cleanly from address 0.
- start pulsed mid-load and in the DONE cycle → ignored: counter, addresses, and flags are unaffected.
